// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
// Holds the frame state encoding and the line levels used on the wire.
// No logic; imported by every serial block.
package serial_pkg;

    // Frame sequencing states, 3-bit encoding shared with the receiver.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Line levels: the line rests high and each frame opens with a low start bit.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Purpose: modulo-CLKS_PER_BIT bit-period counter; tick marks the last clock of a bit.
// Latency: tick is decoded combinationally from the registered count.
// Backpressure: none; clr holds the count at zero.
// Ports: clk, rstn (async active-low), clr (sync clear), tick (terminal count),
//        cnt (current position within the bit period).
module bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);
    assign cnt  = cnt_q;

endmodule

// File: rtl/serial_tx.sv
// Purpose: frame transmitter: start, DATA_W bits LSB first, optional even parity, stop.
// Latency: tx leaves idle on the clock after acceptance; a frame is (2+DATA_W+PARITY_EN)*CLKS_PER_BIT clocks.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, not queued.
// Ports: clk, rstn (async active-low), in_data/in_valid/in_ready (word handshake),
//        tx (registered serial line), busy (frame in progress), done (last stop clock).
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    // done is registered, so it is armed one clock before the stop bit's final clock.
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              tick;
    logic [CNT_W-1:0]  cnt;

    // Timer sits at zero while idle, so the first START clock is count 0.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state_q == IDLE),
        .tick (tick),
        .cnt  (cnt)
    );

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = in_data;
                    par_d   = ^in_data;   // parity of the captured word
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx changes on the bit boundary.
        case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = LINE_IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (cnt == DONE_CNT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (CPB=4 plain, CPB=4 with parity, CPB=2 plain).
// Stimulus pushes the expected per-clock {done,tx} sequence; a negedge monitor pops and compares.
// Idle cycles are checked for tx=1/done=0, and a leftover queue while idle is an error.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] in_data  [3];
    logic       in_valid [3];
    logic       rdy_w  [3];
    logic       tx_w   [3];
    logic       busy_w [3];
    logic       done_w [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] q2[$];

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_a (
        .clk(clk), .rstn(rstn), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_b (
        .clk(clk), .rstn(rstn), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_c (
        .clk(clk), .rstn(rstn), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [1:0] q_pop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_push(input int k, input logic [1:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    // Expected frame built from the word: start, LSB-first data, optional parity, stop.
    function automatic void push_frame(input int k, input logic [7:0] w);
        int         cpb;
        int         nbits;
        logic [9:0] bits;
        cpb   = (k == 2) ? 2 : 4;
        nbits = 0;
        bits  = '0;
        bits[nbits] = 1'b0; nbits++;
        for (int i = 0; i < 8; i++) begin
            bits[nbits] = w[i]; nbits++;
        end
        if (k == 1) begin
            bits[nbits] = ^w; nbits++;
        end
        for (int b = 0; b <= nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                if (b == nbits) q_push(k, {(c == cpb - 1), 1'b1});
                else            q_push(k, {1'b0, bits[b]});
            end
        end
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    // Monitor: while busy, every clock must match the next queued {done,tx}.
    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 3; k++) begin
                if (busy_w[k]) begin
                    if (q_size(k) == 0) begin
                        checks++; errors++;
                        $display("FAIL inst%0d busy_unexpected cyc=%0d", k, cyc);
                    end else begin
                        logic [1:0] e;
                        e = q_pop(k);
                        checks++;
                        if ({done_w[k], tx_w[k]} !== e) begin
                            errors++;
                            $display("FAIL inst%0d frame cyc=%0d actual done/tx=%b%b expected=%b",
                                     k, cyc, done_w[k], tx_w[k], e);
                        end
                    end
                end else begin
                    if (q_size(k) != 0) begin
                        checks++; errors++;
                        $display("FAIL inst%0d frame_short cyc=%0d remaining=%0d", k, cyc, q_size(k));
                        while (q_size(k) != 0) void'(q_pop(k));
                    end
                    if (tx_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
                        checks++; errors++;
                        $display("FAIL inst%0d idle_line cyc=%0d actual tx=%b done=%b expected tx=1 done=0",
                                 k, cyc, tx_w[k], done_w[k]);
                    end
                end
            end
        end
    end

    // Present a word from a negedge and wait for it to be accepted; valid stays high on return.
    task automatic send(input int k, input logic [7:0] w, output int acc_cyc);
        int n;
        n = 0;
        in_data[k]  = w;
        in_valid[k] = 1'b1;
        while (!rdy_w[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = -1;
        if (!rdy_w[k]) begin
            checks++; errors++;
            $display("FAIL inst%0d accept_timeout word=%h", k, w);
        end else begin
            @(posedge clk);
            acc_cyc = cyc;
            push_frame(k, w);
            #1;
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_w[k] || q_size(k) != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[k]) begin
            checks++; errors++;
            $display("FAIL inst%0d idle_timeout", k);
        end
        repeat (2) @(negedge clk);
    endtask

    int a1, a2;

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_data[k]  = 8'h00;
            in_valid[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check1("reset_tx", tx_w[k], 1'b1);
            check1("reset_busy", busy_w[k], 1'b0);
            check1("reset_ready", rdy_w[k], 1'b1);
        end
        rstn = 1'b1;
        @(negedge clk);

        // 0xA5, 40-clock frame
        send(0, 8'hA5, a1);
        in_valid[0] = 1'b0;
        wait_idle(0);

        // parity frame for 0x07, parity bit 1, 44 clocks
        send(1, 8'h07, a1);
        in_valid[1] = 1'b0;
        wait_idle(1);

        // CPB=2, 0x80: MSB is the 8th data bit
        send(2, 8'h80, a1);
        in_valid[2] = 1'b0;
        wait_idle(2);

        // valid held high across two words; second accepted 41 clocks after the first
        send(0, 8'h3C, a1);
        send(0, 8'hC3, a2);
        in_valid[0] = 1'b0;
        checks++;
        if (a2 - a1 != 41) begin
            errors++;
            $display("FAIL back_to_back_spacing actual=%0d expected=41", a2 - a1);
        end
        wait_idle(0);

        // in_data changes mid-frame must not reach the line
        send(0, 8'h00, a1);
        in_valid[0] = 1'b0;
        repeat (12) @(negedge clk);
        in_data[0] = 8'hFF;
        wait_idle(0);

        // reset mid-frame aborts at once
        send(0, 8'hA5, a1);
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check1("midreset_tx", tx_w[0], 1'b1);
        check1("midreset_busy", busy_w[0], 1'b0);
        check1("midreset_ready", rdy_w[0], 1'b1);
        check1("midreset_done", done_w[0], 1'b0);
        q0.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check1("post_reset_tx", tx_w[0], 1'b1);

        // frame after reset still correct
        send(0, 8'h5A, a1);
        in_valid[0] = 1'b0;
        wait_idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
